// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
   localparam int REG_ADDR_W = 4;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;
   typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp: flags a load in EX whose destination is read by the instruction in ID
module pipe_hazard_cmp
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_p0_addr,
   input  logic [REG_ADDR_W-1:0] id_p1_addr,
   input  logic                  id_p0_used,
   input  logic                  id_p1_used,
   input  logic [REG_ADDR_W-1:0] ex_dst_addr,
   input  logic                  ex_we,
   input  logic                  ex_mem_re,
   output logic                  load_use
);
   assign load_use = ex_mem_re & ex_we & (ex_dst_addr != REG_ZERO) &
                     ((id_p0_used & (id_p0_addr == ex_dst_addr)) |
                      (id_p1_used & (id_p1_addr == ex_dst_addr)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the IF_ID/ID_EX/EX_MEM/MEM_WB pipeline
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_p0_addr,
   input  logic [REG_ADDR_W-1:0] id_p1_addr,
   input  logic                  id_p0_used,
   input  logic                  id_p1_used,
   input  logic [REG_ADDR_W-1:0] ex_dst_addr,
   input  logic                  ex_we,
   input  logic                  ex_mem_re,
   input  logic                  ex_mispredict,
   input  logic                  mem_req,
   input  logic                  mem_rdy,
   input  logic                  imem_rdy,
   input  logic                  stat_clr,
   output logic                  pc_hold,
   output logic                  pc_redirect,
   output logic                  stall_if_id,
   output logic                  stall_id_ex,
   output logic                  flush_id_ex,
   output logic                  stall_ex_mem,
   output logic                  stall_mem_wb,
   output logic                  mem_err,
   output logic [CNT_W-1:0]      stall_cycles
);
   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   state_t           state;
   logic             flush_pend;
   logic [TMO_W-1:0] tmo_cnt;
   logic             load_use;
   logic             dwait;
   logic             tmo_hit;

   pipe_hazard_cmp u_cmp (
      .id_p0_addr (id_p0_addr),
      .id_p1_addr (id_p1_addr),
      .id_p0_used (id_p0_used),
      .id_p1_used (id_p1_used),
      .ex_dst_addr(ex_dst_addr),
      .ex_we      (ex_we),
      .ex_mem_re  (ex_mem_re),
      .load_use   (load_use)
   );

   assign dwait   = mem_req & ~mem_rdy;
   assign tmo_hit = dwait & (tmo_cnt == TMO_W'(TIMEOUT - 1));

   // priority decode: reset, halt/data wait, mispredict, pending flush, ID/IF stalls
   always_comb begin
      pc_hold      = 1'b0;
      pc_redirect  = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      flush_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      stall_mem_wb = 1'b0;
      if (!rst_n) begin
         pc_hold = 1'b1;
      end else if (state == HALT || dwait) begin
         pc_hold      = 1'b1;
         stall_if_id  = 1'b1;
         stall_id_ex  = 1'b1;
         stall_ex_mem = 1'b1;
         stall_mem_wb = 1'b1;
      end else if (ex_mispredict) begin
         pc_redirect = 1'b1;
         flush_id_ex = 1'b1;
      end else if (flush_pend) begin
         flush_id_ex = 1'b1;
      end else if (load_use || !imem_rdy) begin
         pc_hold     = 1'b1;
         stall_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end
   end

   // FSM, wait timeout and second flush cycle; HALT is left only through reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         flush_pend <= 1'b0;
         tmo_cnt    <= '0;
         mem_err    <= 1'b0;
      end else if (state != HALT) begin
         state      <= tmo_hit ? HALT : dwait ? DWAIT : RUN;
         tmo_cnt    <= dwait ? tmo_cnt + 1'b1 : '0;
         mem_err    <= mem_err | tmo_hit;
         flush_pend <= dwait ? flush_pend : ex_mispredict;
      end
   end

   // saturating count of PC-hold cycles, clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stat_clr)
         stall_cycles <= '0;
      else if (pc_hold && !(&stall_cycles))
         stall_cycles <= stall_cycles + 1'b1;
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a cycle-level behavioural model
module tb_pipe_hazard_ctrl;
   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    id_p0_addr, id_p1_addr, ex_dst_addr;
   logic          id_p0_used, id_p1_used, ex_we, ex_mem_re, ex_mispredict;
   logic          mem_req, mem_rdy, imem_rdy, stat_clr;
   logic          pc_hold, pc_redirect, stall_if_id, stall_id_ex, flush_id_ex;
   logic          stall_ex_mem, stall_mem_wb, mem_err;
   logic [CW-1:0] stall_cycles;
   logic [7:0]    outs;

   int    n_chk = 0;
   int    n_pass = 0;
   string phase = "reset";

   bit m_halt, m_pend, m_err;
   int m_waits, m_cnt;

   pipe_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_p0_addr   (id_p0_addr),
      .id_p1_addr   (id_p1_addr),
      .id_p0_used   (id_p0_used),
      .id_p1_used   (id_p1_used),
      .ex_dst_addr  (ex_dst_addr),
      .ex_we        (ex_we),
      .ex_mem_re    (ex_mem_re),
      .ex_mispredict(ex_mispredict),
      .mem_req      (mem_req),
      .mem_rdy      (mem_rdy),
      .imem_rdy     (imem_rdy),
      .stat_clr     (stat_clr),
      .pc_hold      (pc_hold),
      .pc_redirect  (pc_redirect),
      .stall_if_id  (stall_if_id),
      .stall_id_ex  (stall_id_ex),
      .flush_id_ex  (flush_id_ex),
      .stall_ex_mem (stall_ex_mem),
      .stall_mem_wb (stall_mem_wb),
      .mem_err      (mem_err),
      .stall_cycles (stall_cycles)
   );

   assign outs = {pc_hold, pc_redirect, stall_if_id, stall_id_ex,
                  flush_id_ex, stall_ex_mem, stall_mem_wb, mem_err};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic m_reset();
      m_halt = 0; m_pend = 0; m_err = 0; m_waits = 0; m_cnt = 0;
   endtask

   function automatic logic [7:0] model_out();
      bit ph = 0, rd = 0, si = 0, sx = 0, fl = 0, sm = 0, sw = 0;
      bit dw = mem_req && !mem_rdy;
      bit lu = ex_mem_re && ex_we && ex_dst_addr != 0 &&
               ((id_p0_used && id_p0_addr == ex_dst_addr) ||
                (id_p1_used && id_p1_addr == ex_dst_addr));
      if (!rst_n) ph = 1;
      else if (m_halt || dw) begin ph = 1; si = 1; sx = 1; sm = 1; sw = 1; end
      else if (ex_mispredict) begin rd = 1; fl = 1; end
      else if (m_pend) fl = 1;
      else if (lu || !imem_rdy) begin ph = 1; si = 1; fl = 1; end
      return {ph, rd, si, sx, fl, sm, sw, m_err};
   endfunction

   task automatic tick();
      logic [7:0] e;
      bit dw;
      @(negedge clk);
      e = model_out();
      chk({phase, ":outs"}, outs, e);
      chk({phase, ":cnt"}, stall_cycles, m_cnt);
      @(posedge clk);
      dw = mem_req && !mem_rdy;
      if (!rst_n) m_reset();
      else begin
         if (stat_clr) m_cnt = 0;
         else if (e[7] && m_cnt < CMAX) m_cnt++;
         if (!m_halt) begin
            if (dw) begin
               m_waits++;
               if (m_waits == TMO) begin m_halt = 1; m_err = 1; end
            end else begin
               m_waits = 0;
               m_pend = ex_mispredict;
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      id_p0_addr = 0; id_p1_addr = 0; ex_dst_addr = 0;
      id_p0_used = 0; id_p1_used = 0; ex_we = 0; ex_mem_re = 0;
      ex_mispredict = 0; mem_req = 0; mem_rdy = 1; imem_rdy = 1; stat_clr = 0;
   endtask

   initial begin
      rst_n = 0;
      idle();
      m_reset();
      tick();
      tick();
      rst_n = 1;
      #1 chk("post_reset", outs, 8'h00);

      phase = "ld_use";
      ex_mem_re = 1; ex_we = 1; ex_dst_addr = 3; id_p1_addr = 3; id_p1_used = 1;
      #1 chk("ld_use_stall", {pc_hold, stall_if_id, flush_id_ex}, 3'b111);
      tick();
      idle();
      #1 chk("ld_use_clear", {pc_hold, stall_if_id, flush_id_ex}, 3'b000);
      tick();

      phase = "ld_r0";
      ex_mem_re = 1; ex_we = 1; ex_dst_addr = 0; id_p0_addr = 0; id_p0_used = 1;
      #1 chk("ld_r0_nostall", pc_hold, 1'b0);
      tick();
      idle();

      phase = "mispredict";
      ex_mispredict = 1;
      #1 chk("mp_c1", {pc_redirect, flush_id_ex}, 2'b11);
      tick();
      ex_mispredict = 0;
      #1 chk("mp_c2", {pc_redirect, flush_id_ex}, 2'b01);
      tick();
      #1 chk("mp_c3", flush_id_ex, 1'b0);
      tick();

      phase = "dwait";
      stat_clr = 1;
      tick();
      stat_clr = 0;
      mem_req = 1; mem_rdy = 0;
      repeat (3) tick();
      mem_rdy = 1; mem_req = 0;
      #1 chk("dw_cnt", stall_cycles, 3);
      chk("dw_noflush_after", flush_id_ex, 1'b0);
      tick();

      phase = "mp_in_dwait";
      mem_req = 1; mem_rdy = 0; ex_mispredict = 1;
      #1 chk("mpdw_noflush", {pc_redirect, flush_id_ex, stall_mem_wb}, 3'b001);
      repeat (2) tick();
      mem_rdy = 1;
      #1 chk("mpdw_f1", {pc_redirect, flush_id_ex}, 2'b11);
      tick();
      ex_mispredict = 0; mem_req = 0;
      #1 chk("mpdw_f2", {pc_redirect, flush_id_ex}, 2'b01);
      tick();
      #1 chk("mpdw_f3", flush_id_ex, 1'b0);
      tick();

      phase = "timeout";
      mem_req = 1; mem_rdy = 0;
      repeat (3) tick();
      chk("tmo_not_yet", mem_err, 1'b0);
      tick();
      chk("tmo_err", mem_err, 1'b1);
      idle();
      repeat (3) tick();
      chk("halt_hold", {pc_hold, stall_mem_wb, flush_id_ex}, 3'b110);
      rst_n = 0;
      m_reset();
      #1 chk("halt_rst", outs, 8'h80);
      tick();
      rst_n = 1;
      tick();

      phase = "saturate";
      imem_rdy = 0;
      repeat (18) tick();
      chk("sat_cnt", stall_cycles, CMAX);
      stat_clr = 1;
      tick();
      stat_clr = 0;
      #1 chk("clr_wins", stall_cycles, 0);
      idle();
      tick();

      phase = "random";
      for (int i = 0; i < 1500; i++) begin
         id_p0_addr    = 4'($urandom_range(3));
         id_p1_addr    = 4'($urandom_range(3));
         ex_dst_addr   = 4'($urandom_range(3));
         id_p0_used    = 1'($urandom_range(1));
         id_p1_used    = 1'($urandom_range(1));
         ex_we         = 1'($urandom_range(1));
         ex_mem_re     = 1'($urandom_range(1));
         ex_mispredict = $urandom_range(9) == 0;
         mem_req       = $urandom_range(9) < 3;
         mem_rdy       = $urandom_range(9) < 6;
         imem_rdy      = $urandom_range(9) < 8;
         stat_clr      = $urandom_range(49) == 0;
         if ($urandom_range(59) == 0) begin
            rst_n = 0;
            m_reset();
         end else rst_n = 1;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
